cpu_if_control_arb: RTL and testbench
=====================================

Name: cpu_if_control_arb

Overview:
Multi-requester CPU interface control FSM. Arbitrates NUM_CH read/write requesters onto one shared access path. Tracks the access through read/write active states and inserts a programmable bus-turnaround gap. Aborts hung accesses with a timeout counter and error pulse. Sits between the per-master CPU interface front-ends and the single target access engine that returns access_complete.

Parameters:
NUM_CH, 4, number of requester channels (1..16)
TIMEOUT, 255, max cycles an access may stay active before abort; 0 disables timeout
TURNAROUND, 1, idle gap cycles after each access, during which no grant is issued (0..15)

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-high reset
read  in  NUM_CH  per-channel read request, level
write  in  NUM_CH  per-channel write request, level
access_complete  in  1  target finished current access; sampled only in RD_ACTIVE/WR_ACTIVE
ready  out  1  controller idle, accepting a new request
grant  out  NUM_CH  one-hot owner of the current access; all-zero when no access is active
active_ch  out  max(1,$clog2(NUM_CH))  binary index of the granted channel; 0 when not active
read_busy  out  1  read access in progress
write_busy  out  1  write access in progress
timeout_err  out  1  one-cycle pulse when an access is aborted by timeout

Behaviour:
- States: IDLE, RD_ACTIVE, WR_ACTIVE, TURNAROUND. Illegal encoding -> IDLE on next edge.
- Reset, asynchronous and immediate, also mid-access:
  - state=IDLE, ready=1, grant=0, active_ch=0, read_busy=0, write_busy=0, timeout_err=0.
  - Round-robin pointer set so ch0 has highest priority first.
  - Timeout and turnaround counters = 0.
- All outputs are registered and state-aligned: they change on the same edge as state (no extra lag).
  - ready = (state==IDLE).
  - read_busy = RD_ACTIVE; write_busy = WR_ACTIVE.
  - grant/active_ch are valid only in the active states.
- IDLE:
  - Candidate channels: read[i]|write[i].
  - Winner: first candidate searching upward (wrapping) from last_winner+1.
  - Within the winner, write beats read: WR_ACTIVE if write set, else RD_ACTIVE.
  - No candidate -> stay IDLE.
  - Latency: request high at edge k -> busy/grant high from edge k.
  - last_winner updates on grant.
- RD_ACTIVE/WR_ACTIVE:
  - The access runs until access_complete=1 or timeout. Request deassertion or changes on other channels are ignored.
  - Exit goes to TURNAROUND if TURNAROUND>0, else IDLE.
  - Back-to-back operation with TURNAROUND=0: IDLE is visited for at least 1 cycle between accesses.
- Timeout counter:
  - Cleared on entry to an active state; increments on each active cycle with access_complete=0.
  - If TIMEOUT>0 and the counter == TIMEOUT-1 with access_complete=0 at an edge: abort. timeout_err=1 for exactly the next cycle; exit as for completion.
  - An active phase therefore lasts at most TIMEOUT cycles.
  - access_complete on the same edge as the timeout threshold: completion wins, no error.
- TURNAROUND:
  - Lasts exactly TURNAROUND cycles; ready=0, grant=0; requests are held off, not lost (level).
  - Then IDLE.
- access_complete in IDLE/TURNAROUND is ignored.
- Width: counters are sized for TIMEOUT and TURNAROUND with no wrap before the threshold.

Test Plan:
- Use NUM_CH=4, TIMEOUT=8, TURNAROUND=1 unless stated.
- Reset released, no requests -> ready=1, grant=0000, busy flags 0, timeout_err=0 indefinitely.
- write[2]=1 and read[2]=1 together -> WR_ACTIVE, grant=0100, active_ch=2, write_busy=1. access_complete pulsed on the 3rd active cycle -> 1 TURNAROUND cycle (ready=0), then ready=1.
- read=1111 held constant -> grants in order ch0,ch1,ch2,ch3,ch0, each completed after 1 cycle. read_busy set in every access, write_busy never.
- write[1] granted, access_complete never asserted -> exactly 8 active cycles, then timeout_err=1 for 1 cycle, then TURNAROUND, then IDLE.
  - Repeat with access_complete on the 8th cycle -> no timeout_err.
- Async reset asserted mid-WR_ACTIVE, between clock edges -> outputs return to reset values immediately. After release, ch0 request is granted first even if ch3 is also requesting.
- TURNAROUND=0, TIMEOUT=0, read[0] held 20 cycles, access_complete low -> no abort; access stays active; timeout_err stays 0.

Source files
------------

// File: rtl/cpu_if_control_arb.sv
// Round-robin arbiter and access-tracking FSM that puts NUM_CH read/write requesters onto one
// shared target path. It adds a turnaround gap after each access and aborts accesses that time out.
module cpu_if_control_arb #(
  parameter int NUM_CH     = 4,
  parameter int TIMEOUT    = 255,
  parameter int TURNAROUND = 1,
  localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_CH-1:0] read,
  input  logic [NUM_CH-1:0] write,
  input  logic              access_complete,
  output logic              ready,
  output logic [NUM_CH-1:0] grant,
  output logic [CH_W-1:0]   active_ch,
  output logic              read_busy,
  output logic              write_busy,
  output logic              timeout_err
);

  localparam int TO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int TA_W = (TURNAROUND > 1) ? $clog2(TURNAROUND) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [TA_W-1:0] TA_LAST = TA_W'((TURNAROUND > 0) ? TURNAROUND - 1 : 0);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_WR   = 2'd2,
    S_TA   = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic [TA_W-1:0] ta_cnt_q, ta_cnt_d;
  logic [CH_W-1:0] last_q, last_d;
  logic            err_d;
  logic [CH_W:0]   pick;
  logic            timeout_hit;
  logic            active_d;

  // The search starts one past the previous winner, so the previous winner has the lowest priority.
  function automatic logic [CH_W:0] rr_pick(input logic [NUM_CH-1:0] cand,
                                            input logic [CH_W-1:0]   last);
    logic [CH_W:0] res;
    int            idx;
    res = '0;
    for (int off = 1; off <= NUM_CH; off++) begin
      idx = (int'(last) + off) % NUM_CH;
      if (!res[CH_W] && cand[idx]) res = {1'b1, CH_W'(idx)};
    end
    return res;
  endfunction

  assign pick        = rr_pick(read | write, last_q);
  assign timeout_hit = (TIMEOUT > 0) && (to_cnt_q == TO_LAST);

  // NOTE: every always_comb output gets a default first so no path can leave it unassigned (no latch).
  always_comb begin
    state_d  = state_q;
    to_cnt_d = to_cnt_q;
    ta_cnt_d = ta_cnt_q;
    last_d   = last_q;
    err_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (pick[CH_W]) begin
          last_d   = pick[CH_W-1:0];
          state_d  = write[pick[CH_W-1:0]] ? S_WR : S_RD;
          to_cnt_d = '0;
        end
      end
      S_RD, S_WR: begin
        if (access_complete || timeout_hit) begin
          err_d    = !access_complete;
          state_d  = (TURNAROUND > 0) ? S_TA : S_IDLE;
          ta_cnt_d = '0;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end
      S_TA: begin
        if (ta_cnt_q == TA_LAST) state_d = S_IDLE;
        else                     ta_cnt_d = ta_cnt_q + 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign active_d = (state_d == S_RD) || (state_d == S_WR);

  // Outputs are registered from the next-state values so they switch on the same edge as the state.
  // NOTE: sequential state uses non-blocking assignments only, so all flops update together at the edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      to_cnt_q    <= '0;
      ta_cnt_q    <= '0;
      last_q      <= CH_W'(NUM_CH - 1);
      ready       <= 1'b1;
      grant       <= '0;
      active_ch   <= '0;
      read_busy   <= 1'b0;
      write_busy  <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state_q     <= state_d;
      to_cnt_q    <= to_cnt_d;
      ta_cnt_q    <= ta_cnt_d;
      last_q      <= last_d;
      ready       <= (state_d == S_IDLE);
      grant       <= active_d ? (NUM_CH'(1) << last_d) : '0;
      active_ch   <= active_d ? last_d : '0;
      read_busy   <= (state_d == S_RD);
      write_busy  <= (state_d == S_WR);
      timeout_err <= err_d;
    end
  end

endmodule

// File: tb/tb_cpu_if_control_arb.sv
// Self-checking bench for cpu_if_control_arb. A behavioural model checks outputs every cycle,
// and directed and random traffic run on top of it. A second instance covers TIMEOUT=0 and TURNAROUND=0.
module tb_cpu_if_control_arb;

  localparam int NUM_CH = 4;
  localparam int TO     = 8;
  localparam int TA     = 1;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] read = '0, write = '0;
  logic       ac = 1'b0;
  logic       ready, read_busy, write_busy, timeout_err;
  logic [3:0] grant;
  logic [1:0] active_ch;

  logic [3:0] read0 = '0, write0 = '0;
  logic       ac0 = 1'b0;
  logic       ready0, read_busy0, write_busy0, timeout_err0;
  logic [3:0] grant0;
  logic [1:0] active_ch0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cpu_if_control_arb #(.NUM_CH(NUM_CH), .TIMEOUT(TO), .TURNAROUND(TA)) dut (
    .clk(clk), .reset(reset), .read(read), .write(write), .access_complete(ac),
    .ready(ready), .grant(grant), .active_ch(active_ch), .read_busy(read_busy),
    .write_busy(write_busy), .timeout_err(timeout_err)
  );

  cpu_if_control_arb #(.NUM_CH(NUM_CH), .TIMEOUT(0), .TURNAROUND(0)) dut0 (
    .clk(clk), .reset(reset), .read(read0), .write(write0), .access_complete(ac0),
    .ready(ready0), .grant(grant0), .active_ch(active_ch0), .read_busy(read_busy0),
    .write_busy(write_busy0), .timeout_err(timeout_err0)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model state: phase 0 = waiting for requests, 1 = access running, 2 = turnaround gap.
  int m_phase, m_owner, m_last, m_age, m_gap;
  bit m_wr, m_err;

  task automatic model_reset();
    m_phase = 0; m_owner = 0; m_last = NUM_CH - 1;
    m_age = 0; m_gap = 0; m_wr = 0; m_err = 0;
  endtask

  task automatic model_leave();
    if (TA > 0) begin m_phase = 2; m_gap = TA; end
    else m_phase = 0;
  endtask

  task automatic model_step(input logic [3:0] r, input logic [3:0] w, input logic c);
    bit found;
    int idx;
    m_err = 0;
    found = 0;
    if (m_phase == 0) begin
      for (int off = 1; off <= NUM_CH; off++) begin
        idx = (m_last + off) % NUM_CH;
        if (!found && (r[idx] || w[idx])) begin
          found = 1; m_owner = idx; m_last = idx; m_wr = w[idx]; m_age = 0; m_phase = 1;
        end
      end
    end else if (m_phase == 1) begin
      m_age++;
      if (c) model_leave();
      else if (TO > 0 && m_age == TO) begin m_err = 1; model_leave(); end
    end else begin
      m_gap--;
      if (m_gap == 0) m_phase = 0;
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or posedge reset);
      if (reset) model_reset();
      else model_step(read, write, ac);
    end
  end

  // Compare process: every cycle out of reset, all outputs are checked against the model.
  initial begin
    logic [3:0] eg;
    forever begin
      @(negedge clk);
      if (!reset) begin
        eg = (m_phase == 1) ? 4'(1 << m_owner) : 4'b0;
        check("m_ready", ready, (m_phase == 0));
        check("m_grant", grant, eg);
        check("m_active_ch", active_ch, (m_phase == 1) ? m_owner : 0);
        check("m_read_busy", read_busy, (m_phase == 1) && !m_wr);
        check("m_write_busy", write_busy, (m_phase == 1) && m_wr);
        check("m_timeout_err", timeout_err, m_err);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got running expected done");
    $fatal(1);
  end

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic reset_dut();
    @(negedge clk);
    reset = 1'b1; read = '0; write = '0; ac = 1'b0;
    cyc(); cyc();
    reset = 1'b0;
  endtask

  initial begin
    int n;
    int seq[8];
    reset_dut();

    // Idle after reset
    repeat (5) cyc();
    check("idle_ready", ready, 1);
    check("idle_grant", grant, 0);
    check("idle_busy", {read_busy, write_busy, timeout_err}, 0);

    // Write beats read on the same channel, then complete on the 3rd active cycle
    reset_dut();
    write = 4'b0100; read = 4'b0100;
    cyc();
    check("wr_grant", grant, 4'b0100);
    check("wr_ch", active_ch, 2);
    check("wr_busy", {write_busy, read_busy}, 2'b10);
    cyc(); cyc();
    ac = 1'b1; read = '0; write = '0;
    cyc();
    ac = 1'b0;
    check("ta_ready", ready, 0);
    check("ta_grant", grant, 0);
    cyc();
    check("ta_done_ready", ready, 1);

    // Round robin over four constant readers
    reset_dut();
    read = 4'b1111; ac = 1'b1;
    n = 0;
    for (int i = 0; i < 15; i++) begin
      cyc();
      if (grant != 0) begin
        if (n < 8) seq[n] = active_ch;
        n++;
        check("rr_read_busy", read_busy, 1);
      end
      check("rr_no_write", write_busy, 0);
    end
    check("rr_count", n, 5);
    check("rr_0", seq[0], 0);
    check("rr_1", seq[1], 1);
    check("rr_2", seq[2], 2);
    check("rr_3", seq[3], 3);
    check("rr_4", seq[4], 0);
    read = '0; ac = 1'b0;

    // Timeout on write[1]
    reset_dut();
    write = 4'b0010;
    cyc();
    write = '0;
    check("to_grant", grant, 4'b0010);
    n = 1;
    for (int i = 0; i < 20; i++) begin
      cyc();
      if (write_busy) n++;
      else break;
    end
    check("to_len", n, 8);
    check("to_err", timeout_err, 1);
    check("to_ta", ready, 0);
    cyc();
    check("to_idle", ready, 1);
    check("to_err_pulse", timeout_err, 0);

    // Completion on the 8th cycle wins over the timeout
    reset_dut();
    write = 4'b0010;
    cyc();
    write = '0;
    repeat (7) cyc();
    check("edge_still_busy", write_busy, 1);
    ac = 1'b1;
    cyc();
    ac = 1'b0;
    check("edge_no_err", timeout_err, 0);
    check("edge_done", {write_busy, ready}, 2'b00);

    // Async reset mid-access; afterwards ch0 first even with ch3 requesting
    reset_dut();
    write = 4'b0010;
    cyc();
    write = '0;
    cyc();
    check("pre_rst_busy", write_busy, 1);
    #2 reset = 1'b1;
    #1;
    check("arst_ready", ready, 1);
    check("arst_grant", grant, 0);
    check("arst_flags", {active_ch, read_busy, write_busy, timeout_err}, 0);
    read = 4'b1001;
    @(negedge clk);
    reset = 1'b0;
    cyc();
    check("arst_first_grant", grant, 4'b0001);
    check("arst_first_ch", active_ch, 0);
    read = '0;
    ac = 1'b1;
    cyc();
    ac = 1'b0;

    // Random traffic, checked by the model every cycle
    reset_dut();
    for (int i = 0; i < 400; i++) begin
      cyc();
      read  = 4'($urandom_range(0, 15) & $urandom_range(0, 15));
      write = 4'($urandom_range(0, 15) & $urandom_range(0, 15));
      ac    = ($urandom_range(0, 5) == 0);
    end
    read = '0; write = '0; ac = 1'b0;

    // TIMEOUT=0, TURNAROUND=0 instance
    reset_dut();
    read0 = 4'b0001; ac0 = 1'b0;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      cyc();
      if (read_busy0 && grant0 == 4'b0001 && !timeout_err0) n++;
    end
    check("nto_active_cycles", n, 20);
    check("nto_err", timeout_err0, 0);
    ac0 = 1'b1;
    cyc();
    check("b2b_idle", {ready0, read_busy0}, 2'b10);
    cyc();
    check("b2b_regrant", {ready0, read_busy0}, 2'b01);
    cyc();
    check("b2b_idle2", ready0, 1);
    read0 = '0; ac0 = 1'b0;
    cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
